uc_lit_queue: RTL

//  Parametrised unit-clause literal FIFO between the unit-clause detector (push side) and the BCP engine (pop side).

---
 rtl/uc_pkg.sv | 22 ++
 rtl/uc_lit_queue_if.sv | 40 ++++
 rtl/uc_lit_match.sv | 35 +++
 rtl/uc_lit_queue.sv | 124 ++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types for the unit-clause literal queue.
// A literal is {var_idx, pol}; pol=1 marks the negated form of the variable.
package uc_pkg;

    localparam int UC_LENGTH = 512;
    localparam int VAR_W     = $clog2(UC_LENGTH);
    localparam int LIT_W     = VAR_W + 1;

    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic             pol;
    } uc_lit_t;

    // Same variable, opposite polarity.
    function automatic uc_lit_t lit_complement(input uc_lit_t lit);
        uc_lit_t res;
        res     = lit;
        res.pol = ~lit.pol;
        return res;
    endfunction

endpackage

// File: rtl/uc_lit_queue_if.sv
// Bus between the unit-clause detector / BCP engine side (master) and the
// literal queue (slave).
//
// Handshake: push is a request qualified by push_lit. There is no ready
// signal: the queue accepts a push when no conflict is latched and it is
// not full, or when a pop is accepted in the same cycle. A push that
// finds the queue full is dropped and reported by a one-cycle ovf pulse.
// pop is accepted whenever empty is low, and ucq2eng always shows the head
// literal (first-word-fall-through). flush clears everything synchronously.
interface uc_lit_queue_if
    import uc_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push;
    uc_lit_t          push_lit;
    logic             pop;
    logic             flush;
    uc_lit_t          ucq2eng;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             conflict;
    uc_lit_t          conflict_lit;
    logic             ovf;

    modport master (
        output push, push_lit, pop, flush,
        input  ucq2eng, empty, full, count, conflict, conflict_lit, ovf
    );

    modport slave (
        input  push, push_lit, pop, flush,
        output ucq2eng, empty, full, count, conflict, conflict_lit, ovf
    );

endinterface

// File: rtl/uc_lit_match.sv
// Compares an incoming literal against every queue slot, ignoring slots
// that do not currently hold a queued literal.
//   any_eq  : some valid slot holds exactly this literal
//   any_cmp : some valid slot holds the complement of this literal
module uc_lit_match
    import uc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  uc_lit_t              lit,
    input  uc_lit_t [DEPTH-1:0]  entries,
    input  logic    [DEPTH-1:0]  valid,
    output logic                 any_eq,
    output logic                 any_cmp
);

    uc_lit_t lit_cmp;

    assign lit_cmp = lit_complement(lit);

    // OR-reduce the per-slot equality and complement hits.
    always_comb begin
        any_eq  = 1'b0;
        any_cmp = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i] == lit)) begin
                any_eq = 1'b1;
            end
            if (valid[i] && (entries[i] == lit_cmp)) begin
                any_cmp = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uc_lit_queue.sv
// Unit-clause literal FIFO between the unit-clause detector and the BCP
// engine. First-word-fall-through, wrap-bit pointers, sticky conflict
// detection on complementary literals.
// Optional feature: define UCQ_DEDUP_EN to drop pushes of a literal that is
// already queued (no state change, no ovf).
module uc_lit_queue
    import uc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uc_lit_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

`ifdef UCQ_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    logic    [PW-1:0]    head;
    logic    [PW-1:0]    tail;
    uc_lit_t [DEPTH-1:0] mem;
    logic                conflict_q;
    uc_lit_t             conflict_lit_q;
    logic                ovf_q;

    logic    [PW-1:0]    occ;
    logic                empty_w;
    logic                full_w;
    logic    [DEPTH-1:0] valid;
    logic                any_eq;
    logic                any_cmp;
    logic                pop_acc;
    logic                push_req;
    logic                dup_drop;
    logic                conflict_hit;
    logic                push_acc;
    logic                ovf_hit;

    // Occupancy falls out of the wrap-bit pointers modulo 2*DEPTH.
    assign occ     = tail - head;
    assign empty_w = (head == tail);
    assign full_w  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);

    // A slot is valid when its distance from head is below the occupancy.
    always_comb begin
        logic [AW-1:0] offset;
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = AW'(i) - head[AW-1:0];
            valid[i] = ({1'b0, offset} < occ);
        end
    end

    uc_lit_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .lit     (bus.push_lit),
        .entries (mem),
        .valid   (valid),
        .any_eq  (any_eq),
        .any_cmp (any_cmp)
    );

    // The head being popped this cycle still counts for matching, so the
    // valid mask is deliberately taken before the pop is applied.
    assign pop_acc      = bus.pop && !empty_w && !bus.flush;
    assign push_req     = bus.push && !conflict_q && !bus.flush;
    assign conflict_hit = push_req && any_cmp;
    assign dup_drop     = DEDUP_EN && any_eq;
    assign push_acc     = push_req && !any_cmp && !dup_drop && (!full_w || pop_acc);
    assign ovf_hit      = push_req && !any_cmp && !dup_drop && full_w && !pop_acc;

    // Pointers and flags; flush returns to the post-reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head           <= '0;
            tail           <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            ovf_q          <= 1'b0;
        end else if (bus.flush) begin
            head           <= '0;
            tail           <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            ovf_q          <= 1'b0;
        end else begin
            if (pop_acc) begin
                head <= head + PW'(1);
            end
            if (push_acc) begin
                tail <= tail + PW'(1);
            end
            if (conflict_hit) begin
                conflict_q     <= 1'b1;
                conflict_lit_q <= bus.push_lit;
            end
            ovf_q <= ovf_hit;
        end
    end

    // Entry storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[tail[AW-1:0]] <= bus.push_lit;
        end
    end

    assign bus.ucq2eng      = empty_w ? '0 : mem[head[AW-1:0]];
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = occ;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_lit = conflict_lit_q;
    assign bus.ovf          = ovf_q;

endmodule
